// File: rtl/blake_pkg.sv
// Shared definitions for the BLAKE-512 round controller: FSM states and counter constants.
package blake_pkg;

    localparam int unsigned ROUNDS_DEF = 16;
    localparam int unsigned SIGMA_MOD  = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/blake_round_ctrl.sv
// BLAKE-512 compression sequencer: walks step/diag/round/sigma counters and issues
// init/ena/fin_ena strobes to the blake_rbit state-register bank; all outputs are flops.
module blake_round_ctrl
    import blake_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned GCORES = 2
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       start,
    input  logic       abort,
    output logic       init,
    output logic       ena,
    output logic [3:0] round,
    output logic [3:0] sigma_row,
    output logic [1:0] step,
    output logic       diag,
    output logic       fin_ena,
    output logic       busy,
    output logic       done
);

    localparam int unsigned STEPS = 4 / GCORES;

    state_t     state, state_nxt;
    logic [3:0] round_nxt, sigma_nxt;
    logic [1:0] step_nxt;
    logic       diag_nxt;
    logic       last_c;
    logic       active_c;

    assign last_c   = (round == 4'(ROUNDS - 1)) && diag && (step == 2'(STEPS - 1));
    assign active_c = (state == ST_INIT) || (state == ST_RUN) || (state == ST_FIN);

    // Next-state and counter update; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        round_nxt = round;
        sigma_nxt = sigma_row;
        step_nxt  = step;
        diag_nxt  = diag;

        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_INIT;
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN:  if (last_c) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (abort && active_c) state_nxt = ST_IDLE;

        if (state_nxt == ST_INIT) begin
            round_nxt = 4'd0;
            sigma_nxt = 4'd0;
            step_nxt  = 2'd0;
            diag_nxt  = 1'b0;
        end else if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
            if (step == 2'(STEPS - 1)) begin
                step_nxt = 2'd0;
                diag_nxt = ~diag;
                if (diag) begin
                    round_nxt = round + 4'd1;
                    // Row follows round mod 10 without a divider.
                    sigma_nxt = (sigma_row == 4'(SIGMA_MOD - 1)) ? 4'd0 : sigma_row + 4'd1;
                end
            end else begin
                step_nxt = step + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            round     <= 4'd0;
            sigma_row <= 4'd0;
            step      <= 2'd0;
            diag      <= 1'b0;
            init      <= 1'b0;
            ena       <= 1'b0;
            fin_ena   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            round     <= round_nxt;
            sigma_row <= sigma_nxt;
            step      <= step_nxt;
            diag      <= diag_nxt;
            init      <= (state_nxt == ST_INIT);
            ena       <= (state_nxt == ST_RUN);
            fin_ena   <= (state_nxt == ST_FIN);
            busy      <= (state_nxt == ST_INIT) || (state_nxt == ST_RUN) || (state_nxt == ST_FIN);
            done      <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Directed bench for blake_round_ctrl: default instance plus GCORES=1 and GCORES=4 instances.
module tb_blake_round_ctrl;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic start = 1'b0, abort = 1'b0;
    logic start1 = 1'b0, start4 = 1'b0;

    always #5 clk = ~clk;

    logic       init, ena, fin_ena, busy, done, diag;
    logic [3:0] round, sigma_row;
    logic [1:0] step;

    logic       init1, ena1, fin1, busy1, done1, diag1;
    logic [3:0] round1, sigma1;
    logic [1:0] step1;

    logic       init4, ena4, fin4, busy4, done4, diag4;
    logic [3:0] round4, sigma4;
    logic [1:0] step4;

    blake_round_ctrl dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .init(init), .ena(ena), .round(round), .sigma_row(sigma_row), .step(step),
        .diag(diag), .fin_ena(fin_ena), .busy(busy), .done(done)
    );

    blake_round_ctrl #(.GCORES(1)) dut_g1 (
        .clk(clk), .rstb(rstb), .start(start1), .abort(1'b0),
        .init(init1), .ena(ena1), .round(round1), .sigma_row(sigma1), .step(step1),
        .diag(diag1), .fin_ena(fin1), .busy(busy1), .done(done1)
    );

    blake_round_ctrl #(.GCORES(4)) dut_g4 (
        .clk(clk), .rstb(rstb), .start(start4), .abort(1'b0),
        .init(init4), .ena(ena4), .round(round4), .sigma_row(sigma4), .step(step4),
        .diag(diag4), .fin_ena(fin4), .busy(busy4), .done(done4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int excl_err = 0;
    int cyc = 0;
    int ena_cnt = 0;
    int trace_err = 0;

    typedef struct {
        int          cyc;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] pk(input logic i, input logic e, input logic f, input logic b,
                                       input logic d, input int r, input int s, input int st,
                                       input logic dg);
        return {i, e, f, b, d, 4'(r), 4'(s), 2'(st), dg};
    endfunction

    function automatic logic [15:0] obs();
        return {init, ena, fin_ena, busy, done, round, sigma_row, step, diag};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge; RUN-phase counters checked against a round/diag/step model.
    task automatic tick();
        int j;
        @(posedge clk);
        #1;
        cyc++;
        if (ena) ena_cnt++;
        if (cyc >= 2 && cyc <= 65) begin
            j = cyc - 2;
            if (round != 4'(j / 4) || sigma_row != 4'((j / 4) % 10) ||
                diag != 1'((j / 2) % 2) || step != 2'(j % 2))
                trace_err++;
        end
    endtask

    task automatic run_one(input int bound, output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= bound; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    always @(negedge clk)
        if (rstb && ($countones({init, ena, fin_ena}) > 1)) excl_err++;

    initial begin
        int lat, lat1, lat4, d1, d2, inits, bad_seen, e1, e4, ms1, nz4;

        vecs[0]  = '{1,  pk(1, 0, 0, 1, 0, 0,  0, 0, 0), "init_c1"};
        vecs[1]  = '{2,  pk(0, 1, 0, 1, 0, 0,  0, 0, 0), "run_c2"};
        vecs[2]  = '{3,  pk(0, 1, 0, 1, 0, 0,  0, 1, 0), "run_c3"};
        vecs[3]  = '{4,  pk(0, 1, 0, 1, 0, 0,  0, 0, 1), "run_c4_diag"};
        vecs[4]  = '{6,  pk(0, 1, 0, 1, 0, 1,  1, 0, 0), "run_c6_round1"};
        vecs[5]  = '{26, pk(0, 1, 0, 1, 0, 6,  6, 0, 0), "run_c26"};
        vecs[6]  = '{43, pk(0, 1, 0, 1, 0, 10, 0, 1, 0), "sigma_wrap"};
        vecs[7]  = '{63, pk(0, 1, 0, 1, 0, 15, 5, 1, 0), "run_c63"};
        vecs[8]  = '{65, pk(0, 1, 0, 1, 0, 15, 5, 1, 1), "last_run"};
        vecs[9]  = '{66, pk(0, 0, 1, 1, 0, 15, 5, 1, 1), "fin"};
        vecs[10] = '{67, pk(0, 0, 0, 0, 1, 15, 5, 1, 1), "done"};
        vecs[11] = '{68, pk(0, 0, 0, 0, 0, 15, 5, 1, 1), "idle_hold"};

        #22 rstb = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_main", 32'(obs()), 32'h0);
        chk("reset_g1", 32'({init1, ena1, fin1, busy1, done1, round1, sigma1, step1, diag1}), 32'h0);
        chk("reset_g4", 32'({init4, ena4, fin4, busy4, done4, round4, sigma4, step4, diag4}), 32'h0);

        // Single compression traced against the vector table.
        cyc = 0;
        ena_cnt = 0;
        start = 1'b1;
        for (int v = 0; v < 12; v++) begin
            while (cyc < vecs[v].cyc) begin
                tick();
                start = 1'b0;
            end
            chk(vecs[v].name, 32'(obs()), 32'(vecs[v].exp));
        end
        chk("ena_cycles", 32'(ena_cnt), 32'd64);
        chk("run_trace_errors", 32'(trace_err), 32'd0);

        // Start held high: back-to-back runs, no mid-run acceptance.
        cyc = 1000;
        d1 = -1; d2 = -1; inits = 0;
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (init) inits++;
            if (done) begin
                if (d1 < 0) d1 = c;
                else begin
                    d2 = c;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd67);
        chk("b2b_spacing", 32'(d2 - d1), 32'd68);
        chk("b2b_init_count", 32'(inits), 32'd2);
        tick();
        tick();

        // Abort at RUN cycle 30.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 32; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 7, 7, 0, 1)));
        bad_seen = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (done || fin_ena) bad_seen++;
        end
        chk("abort_no_fin_done", 32'(bad_seen), 32'd0);
        run_one(100, lat);
        chk("abort_next_latency", 32'(lat), 32'd67);
        tick();

        // Asynchronous reset at RUN cycle 10.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 12; c++) tick();
        #1 rstb = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(obs()), 32'h0);
        #10 rstb = 1'b1;
        run_one(100, lat);
        chk("post_reset_latency", 32'(lat), 32'd67);
        tick();

        // GCORES=1 and GCORES=4 instances in parallel.
        e1 = 0; e4 = 0; ms1 = 0; nz4 = 0; lat1 = -1; lat4 = -1;
        start1 = 1'b1;
        start4 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
        for (int c = 2; c <= 200; c++) begin
            tick();
            if (ena1) begin
                e1++;
                if (int'(step1) > ms1) ms1 = int'(step1);
            end
            if (ena4) begin
                e4++;
                if (step4 != 2'd0) nz4++;
            end
            if (done1 && lat1 < 0) lat1 = c;
            if (done4 && lat4 < 0) lat4 = c;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        chk("g1_run_cycles", 32'(e1), 32'd128);
        chk("g4_run_cycles", 32'(e4), 32'd32);
        chk("g1_step_max", 32'(ms1), 32'd3);
        chk("g4_step_nonzero", 32'(nz4), 32'd0);
        chk("g1_latency", 32'(lat1), 32'd131);
        chk("g4_latency", 32'(lat4), 32'd35);

        chk("mutual_exclusion", 32'(excl_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
